// File: rtl/if_fetch.sv
// if_fetch: instruction fetch unit that assembles a 32-bit little-endian
// instruction from four byte reads on a byte-wide memory port.
// Optional feature: define ICACHE_EN to add a direct-mapped one-word-line
// instruction cache (2^ICACHE_INDEX_W lines) in front of the byte fetcher.
module if_fetch #(
    parameter int ICACHE_INDEX_W = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_i,
    input  logic        flush_i,
    input  logic        stall_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_gnt_i,
    input  logic [7:0]  mem_rdata_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o,
    output logic        inst_valid_o,
    output logic        stallreq_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_fetch_pc;
    logic [1:0]  r_byte_cnt;
    logic [23:0] r_word;       // bytes 0..2; byte 3 goes straight to inst_o
    logic [31:0] r_inst;
    logic [31:0] r_inst_pc;
    logic        r_inst_valid;

    logic [31:0] w_addr;
    logic        w_last;       // unflushed final grant: FETCH -> DONE
    logic        w_hit;
    logic [31:0] w_hit_word;

    assign w_addr = r_fetch_pc + {30'd0, r_byte_cnt};
    assign w_last = (r_state == FETCH) && mem_gnt_i && (r_byte_cnt == 2'd3) && !flush_i;

`ifdef ICACHE_EN
    localparam int LINES = 1 << ICACHE_INDEX_W;
    localparam int TAG_W = 30 - ICACHE_INDEX_W;

    logic [31:0]             r_c_data [LINES];
    logic [TAG_W-1:0]        r_c_tag  [LINES];
    logic [LINES-1:0]        r_c_valid;

    logic [ICACHE_INDEX_W-1:0] w_idx;
    logic [TAG_W-1:0]          w_tag;
    logic [ICACHE_INDEX_W-1:0] w_fill_idx;
    logic                      w_fill;

    assign w_idx      = pc_i[ICACHE_INDEX_W+1:2];
    assign w_tag      = pc_i[31:ICACHE_INDEX_W+2];
    assign w_fill_idx = r_fetch_pc[ICACHE_INDEX_W+1:2];
    // Unaligned fetches never touch the cache, neither lookup nor fill.
    assign w_fill     = w_last && (r_fetch_pc[1:0] == 2'b00) && !rst;
    assign w_hit      = (pc_i[1:0] == 2'b00) && r_c_valid[w_idx] && (r_c_tag[w_idx] == w_tag);
    assign w_hit_word = r_c_data[w_idx];

    // Line valid bits: cleared by reset, set on fill.
    always_ff @(posedge clk) begin
        if (rst)
            r_c_valid <= '0;
        else if (w_fill)
            r_c_valid[w_fill_idx] <= 1'b1;
    end

    // Line data and tag storage; no reset needed, guarded by the valid bits.
    always_ff @(posedge clk) begin
        if (w_fill) begin
            r_c_data[w_fill_idx] <= {mem_rdata_i, r_word};
            r_c_tag[w_fill_idx]  <= r_fetch_pc[31:ICACHE_INDEX_W+2];
        end
    end
`else
    assign w_hit      = 1'b0;
    assign w_hit_word = 32'd0;
`endif

    // Fetch FSM: capture pc, collect four bytes, present the word.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_fetch_pc   <= 32'd0;
            r_byte_cnt   <= 2'd0;
            r_word       <= 24'd0;
            r_inst       <= 32'd0;
            r_inst_pc    <= 32'd0;
            r_inst_valid <= 1'b0;
        end else if (flush_i) begin
            // A grant arriving with the flush is swallowed; partial word dropped.
            r_state      <= IDLE;
            r_byte_cnt   <= 2'd0;
            r_inst_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_hit) begin
                        r_inst       <= w_hit_word;
                        r_inst_pc    <= pc_i;
                        r_inst_valid <= 1'b1;
                        r_state      <= DONE;
                    end else begin
                        r_fetch_pc   <= pc_i;
                        r_byte_cnt   <= 2'd0;
                        r_state      <= FETCH;
                    end
                end
                FETCH: begin
                    if (mem_gnt_i) begin
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        case (r_byte_cnt)
                            2'd0: r_word[7:0]   <= mem_rdata_i;
                            2'd1: r_word[15:8]  <= mem_rdata_i;
                            2'd2: r_word[23:16] <= mem_rdata_i;
                            default: begin
                                r_inst       <= {mem_rdata_i, r_word};
                                r_inst_pc    <= r_fetch_pc;
                                r_inst_valid <= 1'b1;
                                r_state      <= DONE;
                            end
                        endcase
                    end
                end
                DONE: begin
                    if (!stall_i) begin
                        r_inst_valid <= 1'b0;
                        r_state      <= IDLE;
                    end
                end
                default: begin
                    r_inst_valid <= 1'b0;
                    r_state      <= IDLE;
                end
            endcase
        end
    end

    // Reset kills the request immediately, even mid-FETCH.
    assign mem_req_o    = (r_state == FETCH) && !rst;
    assign mem_addr_o   = w_addr;
    assign inst_o       = r_inst;
    assign inst_pc_o    = r_inst_pc;
    assign inst_valid_o = r_inst_valid;
    // inst_valid is set exactly while in DONE, so it doubles as "not stalling".
    assign stallreq_o   = !r_inst_valid;

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: a driver issues fetches and plays the byte arbiter,
// pushing expected {pc, word} into a scoreboard; a monitor pops and compares
// on every new instruction delivery and checks inst_o/inst_pc_o stability.
module tb_if_fetch;
    localparam int W = 5;

    logic        clk, rst;
    logic [31:0] pc_i;
    logic        flush_i, stall_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i;
    logic [7:0]  mem_rdata_i;
    logic [31:0] inst_o, inst_pc_o;
    logic        inst_valid_o, stallreq_o;

    if_fetch #(.ICACHE_INDEX_W(W)) dut (
        .clk(clk), .rst(rst), .pc_i(pc_i), .flush_i(flush_i), .stall_i(stall_i),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
        .mem_rdata_i(mem_rdata_i), .inst_o(inst_o), .inst_pc_o(inst_pc_o),
        .inst_valid_o(inst_valid_o), .stallreq_o(stallreq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [63:0] sb_q[$];

    // reference cache contents: line index -> pc of the word held there
    bit          m_v  [int];
    logic [31:0] m_pc [int];

    logic        mon_pv = 1'b0;
    logic [31:0] mon_pi = 32'd0, mon_pp = 32'd0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    // memory contents: 13 00 00 00 at 0..3, an address-dependent pattern elsewhere
    function automatic logic [7:0] mb(input logic [31:0] a);
        logic [7:0] lo;
        if (a < 32'd4) return (a == 32'd0) ? 8'h13 : 8'h00;
        lo = a[7:0] * 8'd7;
        return lo ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'hA5;
    endfunction

    function automatic int line_of(input logic [31:0] pc);
        return int'((pc >> 2) % (32'd1 << W));
    endfunction

    function automatic bit model_hit(input logic [31:0] pc);
`ifdef ICACHE_EN
        int i = line_of(pc);
        return (pc[1:0] == 2'b00) && m_v.exists(i) && (m_pc[i] == pc);
`else
        return (pc == 32'hDEAD_BEEF) && 1'b0;
`endif
    endfunction

    // mode: 0 normal, 1 flush mid-fetch, 2 reset mid-fetch, 3 flush while in DONE
    task automatic run_txn(input logic [31:0] pc, input int mode_in, input int gnt_pct,
                           input int flush_at_in, input int hold_at, input int hold_n,
                           input int stall_n);
        int mode = mode_in;
        int flush_at, grants = 0, withheld = 0, cyc = 0, held = 0;
        bit hit_exp, g;
        logic [31:0] exp_w, a;
        hit_exp = model_hit(pc);
        if (hit_exp && (mode == 1 || mode == 2)) mode = 0;
        flush_at = (flush_at_in < 0) ? int'($urandom_range(0, 3)) : flush_at_in;
        exp_w = {mb(pc + 32'd3), mb(pc + 32'd2), mb(pc + 32'd1), mb(pc)};
        if (mode != 1 && mode != 2) sb_q.push_back({pc, exp_w});
        pc_i = pc;
        forever begin
            @(negedge clk);
            cyc++;
            mem_gnt_i = 1'b0;
            if (inst_valid_o) break;
            chk("stallreq_busy", stallreq_o, 1);
            if (cyc > 300) begin
                n_cmp++; n_err++;
                $display("FAIL timeout: pc %h never delivered", pc);
                if (mode != 1 && mode != 2) void'(sb_q.pop_back());
                return;
            end
            mem_rdata_i = 8'($urandom);
            if (mem_req_o) begin
                a = pc + grants;
                chk("mem_addr", mem_addr_o, a);
                if (mode == 1 && grants == flush_at) begin
                    flush_i = 1'b1; mem_gnt_i = 1'b1; mem_rdata_i = mb(a);
                    @(negedge clk);
                    flush_i = 1'b0; mem_gnt_i = 1'b0;
                    chk("flush_req", mem_req_o, 0);
                    chk("flush_valid", inst_valid_o, 0);
                    return;
                end
                if (mode == 2 && grants == flush_at) begin
                    rst = 1'b1;
                    #1 chk("rst_req_comb", mem_req_o, 0);
                    @(negedge clk);
                    chk("rst_inst", inst_o, 0);
                    chk("rst_inst_pc", inst_pc_o, 0);
                    chk("rst_valid", inst_valid_o, 0);
                    chk("rst_req", mem_req_o, 0);
                    rst = 1'b0;
                    m_v.delete(); m_pc.delete();
                    return;
                end
                if (grants == hold_at && held < hold_n) g = 1'b0;
                else g = ($urandom_range(0, 99) < gnt_pct);
                if (g) begin
                    grants++; mem_gnt_i = 1'b1; mem_rdata_i = mb(a);
                end else begin
                    withheld++;
                    if (grants == hold_at) held++;
                end
            end
        end
        chk("deliver_stallreq", stallreq_o, 0);
        if (hit_exp) begin
            chk("hit_latency", cyc, 1);
            chk("hit_grants", grants, 0);
        end else begin
            chk("miss_grants", grants, 4);
            chk("miss_latency", cyc, 5 + withheld);
        end
        if (pc[1:0] == 2'b00) begin
            m_v[line_of(pc)] = 1'b1;
            m_pc[line_of(pc)] = pc;
        end
        if (stall_n > 0) begin
            stall_i = 1'b1;
            repeat (stall_n) begin
                @(negedge clk);
                chk("stall_valid", inst_valid_o, 1);
                chk("stall_req", mem_req_o, 0);
            end
        end
        if (mode == 3) begin
            stall_i = 1'b1; flush_i = 1'b1;
            @(negedge clk);
            flush_i = 1'b0; stall_i = 1'b0;
            chk("flush_done_valid", inst_valid_o, 0);
            return;
        end
        stall_i = 1'b0;
        @(negedge clk);
        chk("release_valid", inst_valid_o, 0);
        chk("release_req", mem_req_o, 0);
    endtask

    // monitor: score each new delivery; otherwise the instruction must not move
    initial begin
        logic [63:0] e;
        forever begin
            @(posedge clk);
            #2;
            if (inst_valid_o && !mon_pv) begin
                if (sb_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL unexpected_delivery: pc %h inst %h, want none", inst_pc_o, inst_o);
                end else begin
                    e = sb_q.pop_front();
                    chk("deliver_pc", inst_pc_o, e[63:32]);
                    chk("deliver_inst", inst_o, e[31:0]);
                end
            end else if (!rst) begin
                chk("inst_hold", {inst_pc_o, inst_o}, {mon_pp, mon_pi});
            end
            if (inst_valid_o) chk("no_req_in_done", mem_req_o, 0);
            mon_pv = inst_valid_o;
            mon_pi = inst_o;
            mon_pp = inst_pc_o;
        end
    end

    initial begin
        rst = 1'b1; pc_i = 32'd0; flush_i = 1'b0; stall_i = 1'b0;
        mem_gnt_i = 1'b0; mem_rdata_i = 8'd0;
        repeat (3) @(negedge clk);
        chk("reset_inst", inst_o, 0);
        chk("reset_inst_pc", inst_pc_o, 0);
        chk("reset_valid", inst_valid_o, 0);
        chk("reset_req", mem_req_o, 0);
        chk("reset_stallreq", stallreq_o, 1);
        rst = 1'b0;

        run_txn(32'h0000_0000, 0, 100, -1, -1, 0, 0);  // 0x13 word, 5-cycle latency
        run_txn(32'h0000_0200, 0, 100, -1,  2, 3, 0);  // 3-cycle hold at byte 2
        run_txn(32'h0000_0300, 1, 100,  2, -1, 0, 0);  // flush with grant at byte 2
        run_txn(32'h0000_0100, 0, 100, -1, -1, 0, 4);  // stall 4 cycles in DONE
        run_txn(32'h0000_0040, 0, 100, -1, -1, 0, 0);  // conflicting lines
        run_txn(32'h0000_00C0, 0, 100, -1, -1, 0, 0);
        run_txn(32'h0000_0040, 0, 100, -1, -1, 0, 0);
        run_txn(32'h0000_0040, 0, 100, -1, -1, 0, 0);  // hit when cached
        run_txn(32'h0000_0500, 1, 100,  3, -1, 0, 0);  // flush beats final grant
        run_txn(32'h0000_0500, 0, 100, -1, -1, 0, 0);
        run_txn(32'h0000_0600, 2, 100,  2, -1, 0, 0);  // reset mid-fetch
        run_txn(32'hFFFF_FFFC, 0,  70, -1, -1, 0, 1);
        run_txn(32'hFFFF_FFFE, 0,  70, -1, -1, 0, 0);  // address wraps
        run_txn(32'h0000_0040, 0,  70, -1, -1, 0, 0);

        for (int t = 0; t < 120; t++) begin
            int r, md;
            logic [31:0] p;
            r = int'($urandom_range(0, 99));
            p = ($urandom_range(0, 3) << (W + 2)) | ($urandom_range(0, 7) << 2);
            if ($urandom_range(0, 9) == 0) p = p + $urandom_range(1, 3);
            md = (r < 70) ? 0 : (r < 80) ? 1 : (r < 92) ? 3 : 2;
            run_txn(p, md, 60, -1, -1, 0, int'($urandom_range(0, 3)));
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
